master_bridge_async_fifo_rd_ctrl: RTL and testbench
===================================================

# master_bridge_async_fifo_rd_ctrl

Read-side pointer and status controller of the master bridge asynchronous FIFO, clocked in the read (consumer) domain. It takes the write pointer after it has crossed into the read domain through the bit synchronizer. From it the block computes a registered EMPTY, ALMOST_EMPTY and fill level, and drives the read address into the FIFO memory. It also publishes its own Gray-coded read pointer, which a bit synchronizer carries back into the write domain for the full computation.

## Interface
- ADDR_WIDTH, 4, memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- ALMOST_EMPTY_TH, 2, ALMOST_EMPTY asserts when the fill level is at or below this value.

- CLK  in  1  read-domain clock.
- RST  in  1  reset, asynchronous, active-low.
- RD_EN  in  1  consumer read request.
- WR_PTR_GRAY_SYNC  in  ADDR_WIDTH+1  Gray write pointer, already synchronized into the CLK domain.
- RD_ADDR  out  ADDR_WIDTH  memory read address.
- RD_ACCEPT  out  1  combinational; equals RD_EN & ~EMPTY; the memory read strobe.
- RD_PTR_GRAY  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
- EMPTY  out  1  registered; no readable entry.
- ALMOST_EMPTY  out  1  registered.
- RD_LEVEL  out  ADDR_WIDTH+1  registered conservative fill count, range 0..2^ADDR_WIDTH.
- UNDERFLOW  out  1  registered one-cycle pulse; RD_EN was seen while EMPTY.

## Operation
- State: rd_bin (ADDR_WIDTH+1 bits) holds the binary read pointer.
- rd_bin_next = rd_bin + RD_ACCEPT, computed modulo 2^(ADDR_WIDTH+1). The MSB is the wrap bit.
- rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
- RD_ADDR = rd_bin[ADDR_WIDTH-1:0]. It is driven from the register only, with no combinational path from RD_EN.
- Each CLK edge:
  - rd_bin <= rd_bin_next.
  - RD_PTR_GRAY <= rd_gray_next.
  - EMPTY <= (rd_gray_next == WR_PTR_GRAY_SYNC).
- Level computation:
  - wr_bin_sync = Gray-to-binary of WR_PTR_GRAY_SYNC (XOR-prefix from the MSB).
  - level_next = wr_bin_sync - rd_bin_next, modulo 2^(ADDR_WIDTH+1).
  - RD_LEVEL <= level_next.
  - ALMOST_EMPTY <= (level_next <= ALMOST_EMPTY_TH).
- UNDERFLOW <= RD_EN & EMPTY. On underflow the pointer does not move and no memory read is issued.
- Write into the FIFO: the write side is the only source of new entries. This block never modifies WR_PTR_GRAY_SYNC.

## Timing
- Reset (RST low, asynchronous) forces:
  - rd_bin = 0, RD_PTR_GRAY = 0, RD_ADDR = 0.
  - EMPTY = 1, ALMOST_EMPTY = 1.
  - RD_LEVEL = 0, UNDERFLOW = 0.
- Reset release is synchronous to CLK through the existing reset synchronizer.
- Read handshake: a read is accepted on the CLK edge where RD_ACCEPT = 1. The memory captures data at RD_ADDR on that same edge. RD_ADDR advances after the edge.
- Back-to-back reads: allowed every cycle while EMPTY = 0.
  - Reading the last entry sets EMPTY = 1 on the same edge, because EMPTY is computed from rd_gray_next.
  - No extra read can slip through after the last entry.
- EMPTY deassertion latency after a write: 1 write-clock edge (write Gray pointer update), plus NUM_STAGES read-clock edges in the synchronizer, plus 1 CLK edge in this block.
- EMPTY assertion is immediate: 0 cycles of lag after the final accepted read.
- RD_LEVEL is pessimistic. It may under-report by the synchronizer lag and must never over-report.
- Wrap-around: after 2^(ADDR_WIDTH+1) accepted reads rd_bin returns to 0.
  - The wrap bit distinguishes full from empty.
  - Level arithmetic is modular, so no special case exists at the wrap.
- Simultaneous events: a read accept and a WR_PTR_GRAY_SYNC change on the same edge are both reflected in the EMPTY and RD_LEVEL registered on that edge.
- Reset mid-operation: all state returns to reset values immediately, regardless of RD_EN. The write side must be reset in the same reset event.

## Test plan
- Reset: hold RST = 0 with RD_EN = 1 -> EMPTY = 1, ALMOST_EMPTY = 1, RD_LEVEL = 0, RD_ADDR = 0, RD_PTR_GRAY = 0, UNDERFLOW = 0.
- Single entry: drive WR_PTR_GRAY_SYNC 0 -> 1 -> EMPTY = 0 and RD_LEVEL = 1 next edge. Then pulse RD_EN one cycle -> RD_ACCEPT = 1 for that cycle; EMPTY = 1, RD_PTR_GRAY = 5'b00001, RD_ADDR = 1 after the edge.
- Full level: set WR_PTR_GRAY_SYNC = Gray(16) = 5'b11000 with rd_bin = 0 -> RD_LEVEL = 16, ALMOST_EMPTY = 0. Read 14 consecutive cycles -> RD_LEVEL = 2 and ALMOST_EMPTY = 1 on the 14th edge.
- Underflow: with EMPTY = 1, hold RD_EN = 1 for 3 cycles -> UNDERFLOW = 1 for 3 cycles, RD_ACCEPT = 0, RD_ADDR unchanged.
- Wrap-around: stream 40 writes and reads with the write pointer advanced via Gray steps -> RD_PTR_GRAY changes exactly one bit per accepted read. RD_ADDR wraps 15 -> 0. EMPTY = 1 after the 40th read with rd_bin = 8.
- Mid-operation reset: with RD_LEVEL = 5 and reads in progress, pulse RST low for half a cycle -> all outputs return to reset values asynchronously. The first read accepted after release uses RD_ADDR = 0.

Source files
------------

// File: rtl/master_bridge_async_fifo_rd_ctrl.sv
// Read-side pointer and status controller for the master bridge async FIFO.
// Lives in the read (consumer) clock domain. It keeps the binary read pointer
// and publishes its Gray form for the write-domain synchronizer. It compares
// that pointer against the synchronized write pointer to produce registered
// EMPTY, ALMOST_EMPTY, a conservative fill level and an underflow pulse.
module master_bridge_async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH:0]   WR_PTR_GRAY_SYNC,
  output logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RD_ACCEPT,
  output logic [ADDR_WIDTH:0]   RD_PTR_GRAY,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   RD_LEVEL,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH:0] rd_bin_reg;
  logic [ADDR_WIDTH:0] rd_bin_next;
  logic [ADDR_WIDTH:0] rd_gray_next;
  logic [ADDR_WIDTH:0] wr_bin_sync;
  logic [ADDR_WIDTH:0] level_next;

  // A read is only accepted while the registered EMPTY flag is clear, so the
  // last entry can never be read twice.
  assign RD_ACCEPT = RD_EN & ~EMPTY;

  // Memory address comes straight from the pointer register; no path from RD_EN.
  assign RD_ADDR = rd_bin_reg[ADDR_WIDTH-1:0];

  assign rd_bin_next  = rd_bin_reg + {{ADDR_WIDTH{1'b0}}, RD_ACCEPT};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
      assign wr_bin_sync[gi] = ^WR_PTR_GRAY_SYNC[ADDR_WIDTH:gi];
    end
  endgenerate

  // Modular difference; the wrap bit makes a full FIFO read as 2^ADDR_WIDTH.
  // Because the write pointer lags through the synchronizer, this can only
  // under-report the true fill.
  assign level_next = wr_bin_sync - rd_bin_next;

  // Pointer, Gray pointer and status flags, all updated from the next-state
  // pointer so that emptiness is seen on the same edge as the final read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_bin_reg   <= '0;
      RD_PTR_GRAY  <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      RD_LEVEL     <= '0;
      UNDERFLOW    <= 1'b0;
    end else begin
      rd_bin_reg   <= rd_bin_next;
      RD_PTR_GRAY  <= rd_gray_next;
      EMPTY        <= (rd_gray_next == WR_PTR_GRAY_SYNC);
      ALMOST_EMPTY <= (level_next <= AE_TH);
      RD_LEVEL     <= level_next;
      UNDERFLOW    <= RD_EN & EMPTY;
    end
  end

endmodule

// File: tb/tb_master_bridge_async_fifo_rd_ctrl.sv
// Testbench for master_bridge_async_fifo_rd_ctrl. The reference model tracks
// plain integer counts of written and read entries. Every status output is
// derived from those counts (difference, equality, threshold).
module tb_master_bridge_async_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int TH = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RD_EN = 1'b0;
  logic [AW:0]   WR_PTR_GRAY_SYNC = '0;
  logic [AW-1:0] RD_ADDR;
  logic          RD_ACCEPT;
  logic [AW:0]   RD_PTR_GRAY;
  logic          EMPTY;
  logic          ALMOST_EMPTY;
  logic [AW:0]   RD_LEVEL;
  logic          UNDERFLOW;

  master_bridge_async_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_TH(TH)) dut (
    .CLK(CLK), .RST(RST), .RD_EN(RD_EN), .WR_PTR_GRAY_SYNC(WR_PTR_GRAY_SYNC),
    .RD_ADDR(RD_ADDR), .RD_ACCEPT(RD_ACCEPT), .RD_PTR_GRAY(RD_PTR_GRAY),
    .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .RD_LEVEL(RD_LEVEL),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  // Model: total entries written (as seen through the synchronizer) and read.
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit m_empty = 1'b1;
  bit m_under = 1'b0;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = (AW + 1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int lvl;
    lvl = wr_cnt - rd_cnt;
    check({ph, ":empty"},  32'(EMPTY),        32'(m_empty));
    check({ph, ":level"},  32'(RD_LEVEL),     32'(lvl));
    check({ph, ":aempty"}, 32'(ALMOST_EMPTY), 32'(lvl <= TH));
    check({ph, ":addr"},   32'(RD_ADDR),      32'(rd_cnt % (1 << AW)));
    check({ph, ":gray"},   32'(RD_PTR_GRAY),  32'(gray_of(rd_cnt)));
    check({ph, ":under"},  32'(UNDERFLOW),    32'(m_under));
  endtask

  // One clock cycle: drive inputs after the falling edge, check the strobe,
  // advance the model at the rising edge, then check registered outputs.
  task automatic step(input string ph, input bit rd_en, input int wr_new);
    bit acc;
    RD_EN = rd_en;
    wr_cnt = wr_new;
    WR_PTR_GRAY_SYNC = gray_of(wr_cnt);
    #1;
    acc = rd_en && !m_empty;
    check({ph, ":accept"}, 32'(RD_ACCEPT), 32'(acc));
    @(posedge CLK);
    m_under = rd_en && m_empty;
    if (acc) rd_cnt++;
    m_empty = (wr_cnt == rd_cnt);
    #1;
    check_all(ph);
    $display("[TB] %s rd_en=%0d wr=%0d rd=%0d level=%0d empty=%0d", ph, rd_en, wr_cnt, rd_cnt,
             RD_LEVEL, EMPTY);
    @(negedge CLK);
  endtask

  initial begin
    int w;
    bit re;

    // Reset held with a pending read request
    RST = 1'b0;
    RD_EN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    check("reset:accept", 32'(RD_ACCEPT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Single entry written then read
    step("single_wr", 1'b0, 1);
    step("single_rd", 1'b1, 1);

    // Underflow for three cycles
    repeat (3) step("underflow", 1'b1, wr_cnt);

    // Fill to the full level, then read down to the threshold and drain
    step("full", 1'b0, rd_cnt + 16);
    repeat (14) step("read14", 1'b1, wr_cnt);
    repeat (2) step("drain", 1'b1, wr_cnt);

    // Wrap-around streaming: one write and one read request every cycle
    for (int i = 0; i < 40; i++) step("wrap", 1'b1, wr_cnt + 1);
    for (int i = 0; i < 20 && !m_empty; i++) step("wrap_drain", 1'b1, wr_cnt);

    // Randomized traffic, including multi-entry synchronizer jumps
    for (int i = 0; i < 300; i++) begin
      w = wr_cnt + int'($urandom_range(0, 2));
      if (w > rd_cnt + 16) w = rd_cnt + 16;
      re = ($urandom_range(0, 3) != 0);
      step("random", re, w);
    end

    // Mid-operation reset with reads in flight
    step("pre_rst", 1'b0, rd_cnt + 5);
    step("pre_rst_rd", 1'b1, wr_cnt);
    RD_EN = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    wr_cnt = 0;
    rd_cnt = 0;
    m_empty = 1'b1;
    m_under = 1'b0;
    WR_PTR_GRAY_SYNC = '0;
    #1;
    check_all("midrst");
    @(negedge CLK);
    RST = 1'b1;
    step("post_rst_wr", 1'b0, 3);
    step("post_rst_rd", 1'b1, 3);
    step("post_rst_rd2", 1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
